// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: cache busywaits, taken branches, load-use hazards,
// a redirect held pending across an I-cache miss, and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_busywait,
    input  logic              d_busywait,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_rd,
    input  logic              ex_taken,
    input  logic [ADDR_W-1:0] ex_target,
    input  logic              perf_clr,
    output logic              pc_stall,
    output logic              pc_redirect,
    output logic [ADDR_W-1:0] pc_target,
    output logic              ifid_stall,
    output logic              ifid_flush,
    output logic              idex_stall,
    output logic              idex_flush,
    output logic              exmem_stall,
    output logic              memwb_stall,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MEM_WAIT   = 2'd1,
        FETCH_WAIT = 2'd2,
        REDIR_PEND = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_pend_target;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;

    logic                w_load_use;
    logic                w_pend_load;
    logic                w_flush_inc;
    logic                w_pc_stall;
    logic                w_pc_redirect;
    logic [ADDR_W-1:0]   w_pc_target;
    logic                w_ifid_stall;
    logic                w_ifid_flush;
    logic                w_idex_stall;
    logic                w_idex_flush;
    logic                w_exmem_stall;
    logic                w_memwb_stall;

    assign w_load_use = ex_mem_read && (ex_rd != 5'd0) &&
                        ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

    // Branches are ordered by priority; only one source drives the controls in a cycle.
    always_comb begin
        w_next        = r_state;
        w_pend_load   = 1'b0;
        w_flush_inc   = 1'b0;
        w_pc_stall    = 1'b0;
        w_pc_redirect = 1'b0;
        w_pc_target   = '0;
        w_ifid_stall  = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_stall  = 1'b0;
        w_idex_flush  = 1'b0;
        w_exmem_stall = 1'b0;
        w_memwb_stall = 1'b0;
        if (d_busywait) begin
            w_pc_stall    = 1'b1;
            w_ifid_stall  = 1'b1;
            w_idex_stall  = 1'b1;
            w_exmem_stall = 1'b1;
            w_memwb_stall = 1'b1;
            if (r_state != REDIR_PEND)
                w_next = MEM_WAIT;
        end else if (r_state == REDIR_PEND) begin
            w_ifid_flush = 1'b1;
            if (i_busywait) begin
                w_pc_stall = 1'b1;
            end else begin
                w_pc_redirect = 1'b1;
                w_pc_target   = r_pend_target;
                w_next        = RUN;
            end
        end else if (ex_taken) begin
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
            w_flush_inc  = 1'b1;
            if (i_busywait) begin
                w_pc_stall  = 1'b1;
                w_pend_load = 1'b1;
                w_next      = REDIR_PEND;
            end else begin
                w_pc_redirect = 1'b1;
                w_pc_target   = ex_target;
                w_next        = RUN;
            end
        end else if (i_busywait) begin
            w_pc_stall   = 1'b1;
            w_ifid_flush = 1'b1;
            w_next       = FETCH_WAIT;
        end else begin
            w_next = RUN;
            if (w_load_use) begin
                w_pc_stall   = 1'b1;
                w_ifid_stall = 1'b1;
                w_idex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= RUN;
            r_pend_target <= '0;
        end else begin
            r_state <= w_next;
            if (w_pend_load)
                r_pend_target <= ex_target;
        end
    end

    // Counters saturate at all-ones; a clear request beats a same-cycle increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (perf_clr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_pc_stall && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush_inc && (r_flush_cnt != {CNT_W{1'b1}}))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign pc_stall    = w_pc_stall    & ~reset;
    assign pc_redirect = w_pc_redirect & ~reset;
    assign pc_target   = reset ? '0 : w_pc_target;
    assign ifid_stall  = w_ifid_stall  & ~reset;
    assign ifid_flush  = w_ifid_flush  & ~reset;
    assign idex_stall  = w_idex_stall  & ~reset;
    assign idex_flush  = w_idex_flush  & ~reset;
    assign exmem_stall = w_exmem_stall & ~reset;
    assign memwb_stall = w_memwb_stall & ~reset;
    assign state       = r_state;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: vector table for single-cycle decisions plus hand-written
// sequences for pending redirect, D-cache hold, reset during a pending redirect and counter saturation.
module tb_pipeline_hazard_ctrl;
    localparam int CNT_W  = 16;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_busywait, d_busywait;
    logic [4:0]        id_rs1, id_rs2;
    logic              id_use_rs1, id_use_rs2;
    logic              ex_mem_read;
    logic [4:0]        ex_rd;
    logic              ex_taken;
    logic [ADDR_W-1:0] ex_target;
    logic              perf_clr;
    logic              pc_stall, pc_redirect;
    logic [ADDR_W-1:0] pc_target;
    logic              ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_stall;
    logic [1:0]        state;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    logic [41:0] exp_q[$];

    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .i_busywait(i_busywait), .d_busywait(d_busywait),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_taken(ex_taken), .ex_target(ex_target),
        .perf_clr(perf_clr), .pc_stall(pc_stall), .pc_redirect(pc_redirect), .pc_target(pc_target),
        .ifid_stall(ifid_stall), .ifid_flush(ifid_flush), .idex_stall(idex_stall),
        .idex_flush(idex_flush), .exmem_stall(exmem_stall), .memwb_stall(memwb_stall),
        .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // ctl bit order: pc_stall, pc_redirect, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_stall
    typedef struct packed {
        logic        ib;
        logic        db;
        logic        tk;
        logic [31:0] tgt;
        logic        mr;
        logic [4:0]  rd;
        logic        u1;
        logic [4:0]  rs1;
        logic        u2;
        logic [4:0]  rs2;
        logic [7:0]  ctl;
        logic [31:0] etgt;
        logic [1:0]  st;
    } vec_t;

    localparam logic [7:0] C_NONE = 8'h00;
    localparam logic [7:0] C_LU   = 8'hA4;
    localparam logic [7:0] C_BR   = 8'h54;
    localparam logic [7:0] C_BRW  = 8'h94;
    localparam logic [7:0] C_IB   = 8'h90;
    localparam logic [7:0] C_DB   = 8'hAB;
    localparam logic [7:0] C_REL  = 8'h50;

    function automatic vec_t mk(input logic ib, input logic db, input logic tk, input logic [31:0] tgt,
                                input logic mr, input logic [4:0] rd, input logic u1, input logic [4:0] rs1,
                                input logic u2, input logic [4:0] rs2, input logic [7:0] ctl,
                                input logic [31:0] etgt, input logic [1:0] st);
        vec_t v;
        v.ib = ib; v.db = db; v.tk = tk; v.tgt = tgt; v.mr = mr; v.rd = rd;
        v.u1 = u1; v.rs1 = rs1; v.u2 = u2; v.rs2 = rs2;
        v.ctl = ctl; v.etgt = etgt; v.st = st;
        return v;
    endfunction

    function automatic vec_t cyc(input logic ib, input logic db, input logic tk, input logic [31:0] tgt,
                                 input logic [7:0] ctl, input logic [31:0] etgt, input logic [1:0] st);
        return mk(ib, db, tk, tgt, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, ctl, etgt, st);
    endfunction

    task automatic drive(input vec_t v);
        i_busywait  = v.ib;
        d_busywait  = v.db;
        ex_taken    = v.tk;
        ex_target   = v.tgt;
        ex_mem_read = v.mr;
        ex_rd       = v.rd;
        id_use_rs1  = v.u1;
        id_rs1      = v.rs1;
        id_use_rs2  = v.u2;
        id_rs2      = v.rs2;
    endtask

    task automatic step(input vec_t v, input string name);
        logic [41:0] got;
        logic [41:0] e;
        drive(v);
        exp_q.push_back({v.ctl, v.etgt, v.st});
        @(negedge clk);
        got = {pc_stall, pc_redirect, ifid_stall, ifid_flush, idex_stall, idex_flush,
               exmem_stall, memwb_stall, pc_target, state};
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL %s: got ctl=%h tgt=%h st=%0d, want ctl=%h tgt=%h st=%0d",
                     name, got[41:34], got[33:2], got[1:0], e[41:34], e[33:2], e[1:0]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [CNT_W-1:0] got, input logic [CNT_W-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    vec_t tbl[13];

    initial begin
        tbl[0]  = mk(0,0,0,32'h0,   0,5'd0,0,5'd0,0,5'd0, C_NONE, 32'h0,   2'd0);
        tbl[1]  = mk(0,0,0,32'h0,   1,5'd5,1,5'd5,0,5'd0, C_LU,   32'h0,   2'd0);
        tbl[2]  = mk(0,0,0,32'h0,   1,5'd7,1,5'd3,1,5'd7, C_LU,   32'h0,   2'd0);
        tbl[3]  = mk(0,0,0,32'h0,   1,5'd0,1,5'd0,0,5'd0, C_NONE, 32'h0,   2'd0);
        tbl[4]  = mk(0,0,0,32'h0,   1,5'd5,0,5'd5,0,5'd0, C_NONE, 32'h0,   2'd0);
        tbl[5]  = mk(0,0,1,32'h100, 0,5'd0,0,5'd0,0,5'd0, C_BR,   32'h100, 2'd0);
        tbl[6]  = mk(0,0,1,32'h140, 1,5'd9,1,5'd9,0,5'd0, C_BR,   32'h140, 2'd0);
        tbl[7]  = mk(1,0,0,32'h0,   0,5'd0,0,5'd0,0,5'd0, C_IB,   32'h0,   2'd0);
        tbl[8]  = mk(1,0,0,32'h0,   0,5'd0,0,5'd0,0,5'd0, C_IB,   32'h0,   2'd2);
        tbl[9]  = mk(0,0,0,32'h0,   1,5'd4,0,5'd0,1,5'd4, C_LU,   32'h0,   2'd2);
        tbl[10] = mk(0,0,0,32'h0,   0,5'd0,0,5'd0,0,5'd0, C_NONE, 32'h0,   2'd0);
        tbl[11] = mk(1,0,0,32'h0,   1,5'd6,1,5'd6,0,5'd0, C_IB,   32'h0,   2'd0);
        tbl[12] = mk(0,0,0,32'h0,   0,5'd0,0,5'd0,0,5'd0, C_NONE, 32'h0,   2'd2);

        perf_clr = 1'b0;
        reset    = 1'b1;
        // Outputs must stay low under reset even with every request active.
        step(mk(1,1,1,32'hDEAD, 1,5'd5,1,5'd5,0,5'd0, C_NONE, 32'h0, 2'd0), "reset_gate");
        chk("reset_stall_cnt", stall_cnt, 16'd0);
        chk("reset_flush_cnt", flush_cnt, 16'd0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++)
            step(tbl[i], $sformatf("vec%0d", i));
        chk("tbl_stall_cnt", stall_cnt, 16'd6);
        chk("tbl_flush_cnt", flush_cnt, 16'd2);

        // Taken branch during an I-miss: redirect held, later taken branch ignored while pending.
        step(cyc(1,0,1,32'h200, C_BRW, 32'h0,   2'd0), "pend_take");
        step(cyc(1,0,0,32'h0,   C_IB,  32'h0,   2'd3), "pend_wait1");
        step(cyc(1,0,1,32'h300, C_IB,  32'h0,   2'd3), "pend_wait2");
        step(cyc(0,0,0,32'h0,   C_REL, 32'h200, 2'd3), "pend_release");
        step(cyc(0,0,0,32'h0,   C_NONE,32'h0,   2'd0), "pend_after");
        chk("pend_flush_cnt", flush_cnt, 16'd3);
        chk("pend_stall_cnt", stall_cnt, 16'd9);

        // D-cache hold masks a taken branch until released.
        for (int i = 0; i < 4; i++)
            step(cyc(0,1,1,32'h400, C_DB, 32'h0, (i == 0) ? 2'd0 : 2'd1), $sformatf("dhold%0d", i));
        chk("dhold_flush_cnt", flush_cnt, 16'd3);
        step(cyc(0,0,1,32'h400, C_BR,  32'h400, 2'd1), "dhold_release");
        step(cyc(0,0,0,32'h0,   C_NONE,32'h0,   2'd0), "dhold_after");
        chk("dhold_rel_flush_cnt", flush_cnt, 16'd4);

        // D-cache hold arriving while a redirect is pending keeps it pending.
        step(cyc(1,0,1,32'h500, C_BRW, 32'h0,   2'd0), "pd_take");
        step(cyc(1,1,0,32'h0,   C_DB,  32'h0,   2'd3), "pd_dhold");
        step(cyc(0,0,0,32'h0,   C_REL, 32'h500, 2'd3), "pd_release");
        step(cyc(0,0,0,32'h0,   C_NONE,32'h0,   2'd0), "pd_after");
        chk("pd_stall_cnt", stall_cnt, 16'd15);
        chk("pd_flush_cnt", flush_cnt, 16'd5);

        // Reset while a redirect is pending discards it.
        step(cyc(1,0,1,32'h600, C_BRW, 32'h0, 2'd0), "rst_take");
        step(cyc(1,0,0,32'h0,   C_IB,  32'h0, 2'd3), "rst_pending");
        reset = 1'b1;
        step(cyc(1,0,0,32'h0,   C_NONE,32'h0, 2'd0), "rst_mid");
        chk("rst_mid_stall_cnt", stall_cnt, 16'd0);
        chk("rst_mid_flush_cnt", flush_cnt, 16'd0);
        reset = 1'b0;
        step(cyc(0,0,0,32'h0,   C_NONE,32'h0, 2'd0), "rst_after1");
        step(cyc(0,0,0,32'h0,   C_NONE,32'h0, 2'd0), "rst_after2");

        // Saturation and clear.
        step(cyc(0,0,1,32'h700, C_BR, 32'h700, 2'd0), "sat_take");
        drive(cyc(1,0,0,32'h0, C_NONE, 32'h0, 2'd0));
        repeat (65540) @(posedge clk);
        #1;
        chk("sat_stall_cnt", stall_cnt, 16'hFFFF);
        chk("sat_flush_cnt", flush_cnt, 16'd1);
        step(cyc(1,0,0,32'h0, C_IB, 32'h0, 2'd2), "sat_more");
        chk("sat_hold_stall_cnt", stall_cnt, 16'hFFFF);
        perf_clr = 1'b1;
        @(posedge clk);
        #1;
        perf_clr = 1'b0;
        chk("clr_stall_cnt", stall_cnt, 16'd0);
        chk("clr_flush_cnt", flush_cnt, 16'd0);
        step(cyc(0,0,0,32'h0, C_NONE, 32'h0, 2'd2), "clr_idle");
        chk("clr_idle_stall_cnt", stall_cnt, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
